// File: rtl/button_event_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | button_event_scheduler_if : button inputs and event handshake bundle        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface button_event_scheduler_if #(
  parameter int SIGNAL_BIT_WIDTH = 8,
  parameter int INDEX_BIT_WIDTH  = 3
);
  logic [SIGNAL_BIT_WIDTH-1:0] signals_debounced_n;
  logic                        event_valid;
  logic [INDEX_BIT_WIDTH-1:0]  event_index;
  logic                        event_ready;
  logic [SIGNAL_BIT_WIDTH-1:0] pending;
  logic                        overflow;
  logic                        overflow_clear;

  modport master (
    output signals_debounced_n,
    output event_ready,
    output overflow_clear,
    input  event_valid,
    input  event_index,
    input  pending,
    input  overflow
  );

  modport slave (
    input  signals_debounced_n,
    input  event_ready,
    input  overflow_clear,
    output event_valid,
    output event_index,
    output pending,
    output overflow
  );
endinterface

`default_nettype wire

// File: rtl/button_event_scheduler.sv
// +----------------------------------------------------------------------------+
// | button_event_scheduler : press edges -> pending -> round-robin -> FIFO      |
// | Optional auto-repeat enabled by macro BUTTON_EVENT_REPEAT_EN. Revision: 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module button_event_scheduler #(
  parameter int SIGNAL_BIT_WIDTH     = 8,
  parameter int INDEX_BIT_WIDTH      = 3,
  parameter int FIFO_DEPTH           = 4,
  parameter int FIFO_DEPTH_BIT_WIDTH = 2,
  parameter int REPEAT_DELAY         = 16,
  parameter int REPEAT_PERIOD        = 4,
  parameter int REPEAT_BIT_WIDTH     = 5
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  button_event_scheduler_if.slave bus
);

  localparam int c_cnt_w  = FIFO_DEPTH_BIT_WIDTH + 1;
  localparam int c_scan_w = INDEX_BIT_WIDTH + 1;
  localparam logic [c_cnt_w-1:0]         c_full = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_scan_w-1:0]        c_nsig = c_scan_w'(SIGNAL_BIT_WIDTH);
  localparam logic [INDEX_BIT_WIDTH-1:0] c_last = INDEX_BIT_WIDTH'(SIGNAL_BIT_WIDTH - 1);

  if ((SIGNAL_BIT_WIDTH > (1 << INDEX_BIT_WIDTH)) ||
      (FIFO_DEPTH != (1 << FIFO_DEPTH_BIT_WIDTH)) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
      (REPEAT_DELAY >= (1 << REPEAT_BIT_WIDTH))) begin : g_bad_params
    $error("button_event_scheduler: inconsistent parameters");
  end

  logic [SIGNAL_BIT_WIDTH-1:0] r_prev_n;
  logic [SIGNAL_BIT_WIDTH-1:0] r_pending;
  logic                        r_overflow;
  logic [INDEX_BIT_WIDTH-1:0]  r_rr_ptr;
  logic [INDEX_BIT_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BIT_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BIT_WIDTH-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]          r_count;

  logic [SIGNAL_BIT_WIDTH-1:0] w_edge;
  logic [SIGNAL_BIT_WIDTH-1:0] w_grant_vec;
  logic [SIGNAL_BIT_WIDTH-1:0] w_repeat_vec;
  logic [SIGNAL_BIT_WIDTH-1:0] w_lost;
  logic [c_scan_w-1:0]         w_scan;
  logic [INDEX_BIT_WIDTH-1:0]  w_grant_idx;
  logic                        w_grant;
  logic                        w_pop;
  logic                        w_valid;

  assign w_edge  = r_prev_n & ~bus.signals_debounced_n;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.event_ready;

  // Eligibility uses the pre-pop count, so a full FIFO never grants even while popping.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < SIGNAL_BIT_WIDTH; k++) begin
      w_scan = {1'b0, r_rr_ptr} + c_scan_w'(k);
      if (w_scan >= c_nsig) w_scan = w_scan - c_nsig;
      if (!w_grant && (r_count != c_full) && r_pending[w_scan[INDEX_BIT_WIDTH-1:0]]) begin
        w_grant     = 1'b1;
        w_grant_idx = w_scan[INDEX_BIT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_grant_vec = '0;
    if (w_grant) w_grant_vec[w_grant_idx] = 1'b1;
  end

  // A press on a bit being granted this cycle is a fresh request, not a loss.
  assign w_lost = w_edge & r_pending & ~w_grant_vec;

`ifdef BUTTON_EVENT_REPEAT_EN
  logic                        r_rep_active;
  logic [INDEX_BIT_WIDTH-1:0]  r_rep_target;
  logic [REPEAT_BIT_WIDTH-1:0] r_rep_cnt;
  logic [INDEX_BIT_WIDTH-1:0]  w_first_edge;
  logic                        w_rep_fire;

  always_comb begin
    w_first_edge = '0;
    for (int i = SIGNAL_BIT_WIDTH - 1; i >= 0; i--)
      if (w_edge[i]) w_first_edge = INDEX_BIT_WIDTH'(i);
  end

  assign w_rep_fire = r_rep_active && !bus.signals_debounced_n[r_rep_target] &&
                      (r_rep_cnt == '0);

  always_comb begin
    w_repeat_vec = '0;
    if (w_rep_fire) w_repeat_vec[r_rep_target] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_active <= 1'b0;
      r_rep_target <= '0;
      r_rep_cnt    <= '0;
    end else if (|w_edge) begin
      r_rep_active <= 1'b1;
      r_rep_target <= w_first_edge;
      r_rep_cnt    <= REPEAT_BIT_WIDTH'(REPEAT_DELAY - 1);
    end else if (r_rep_active) begin
      if (bus.signals_debounced_n[r_rep_target]) r_rep_active <= 1'b0;
      else if (r_rep_cnt == '0) r_rep_cnt <= REPEAT_BIT_WIDTH'(REPEAT_PERIOD - 1);
      else r_rep_cnt <= r_rep_cnt - 1'b1;
    end
  end
`else
  assign w_repeat_vec = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_n   <= '1;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      r_prev_n  <= bus.signals_debounced_n;
      r_pending <= (r_pending & ~w_grant_vec) | w_edge | w_repeat_vec;
      if (|w_lost) r_overflow <= 1'b1;
      else if (bus.overflow_clear) r_overflow <= 1'b0;
      if (w_grant) r_rr_ptr <= (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_grant) begin
        r_mem[r_wr_ptr] <= w_grant_idx;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.event_valid = w_valid;
  assign bus.event_index = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.pending     = r_pending;
  assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: doc/button_event_scheduler.md
# button_event_scheduler

Sequences the debounced, active-low pushbutton vector from `debounce_vector` into a stream of discrete button events. It detects press edges, holds them as per-button pending requests, and shares one event FIFO between all buttons with a round-robin arbiter. It presents one event at a time to the consumer (menu/control logic) over a valid/ready handshake. Optional auto-repeat turns a held button into periodic events.

## Interface
Parameters:
- `SIGNAL_BIT_WIDTH`, 8: number of buttons.
- `INDEX_BIT_WIDTH`, 3: event index width; SIGNAL_BIT_WIDTH ≤ 2^INDEX_BIT_WIDTH.
- `FIFO_DEPTH`, 4: event FIFO entries.
- `FIFO_DEPTH_BIT_WIDTH`, 2: log2(FIFO_DEPTH).
- `REPEAT_DELAY`, 16: cycles from press edge to first repeat.
- `REPEAT_PERIOD`, 4: cycles between subsequent repeats.
- `REPEAT_BIT_WIDTH`, 5: repeat counter width; must hold REPEAT_DELAY.

Ports:
- `clk`  in  1: single clock, same clock domain as the debounced signals.
- `reset_n`  in  1: asynchronous, active-low reset.
- `signals_debounced_n`  in  SIGNAL_BIT_WIDTH: debounced buttons; 0 = pressed.
- `event_valid`  out  1: FIFO head holds an event.
- `event_index`  out  INDEX_BIT_WIDTH: button index of the FIFO head.
- `event_ready`  in  1: consumer accepts the head event.
- `pending`  out  SIGNAL_BIT_WIDTH: per-button request not yet written into the FIFO.
- `overflow`  out  1: sticky flag; a press was lost.
- `overflow_clear`  in  1: clears `overflow`.

## Operation
- `prev_n` register samples `signals_debounced_n` every cycle and resets to all ones. Press edge on bit i = `prev_n[i] & ~signals_debounced_n[i]`.
- Edge on bit i sets `pending[i]`.
  - If `pending[i]` is already set and is not granted this cycle, the edge is dropped and `overflow` is set.
- Arbiter:
  - Grants when the FIFO is not full (registered count) and `pending` is nonzero.
  - Search starts at `rr_ptr` and wraps; the first set bit wins.
  - The granted index is written into the FIFO and its pending bit is cleared.
  - `rr_ptr` becomes (granted+1) mod SIGNAL_BIT_WIDTH. Reset value of `rr_ptr` is 0. At most one grant per cycle.
- Grant and new edge on the same bit in the same cycle: the bit stays pending and no overflow is raised; the new press counts as a fresh request.
- FIFO:
  - `event_valid` = not empty. `event_index` = head entry, fall-through.
  - Pop on `event_valid & event_ready`; `event_ready` while empty is ignored.
- At full, a pop and a grant in the same cycle are not both allowed. Grant eligibility uses the count before the pop, so no grant occurs that cycle.
- `overflow`:
  - `overflow_clear` clears it.
  - When clear and a new loss happen in the same cycle, set wins.
- Reset values: `event_valid`=0, `event_index`=0, `pending`=0, `overflow`=0, FIFO empty, repeat idle.
- A mid-operation reset discards all queued and pending events immediately (asynchronous).

## Timing
- Input goes low before edge k: `pending[i]`=1 after edge k.
- Granted at edge k+1: `event_valid`=1 after edge k+1. Press-to-valid latency is 2 cycles when the FIFO is not full.
- Throughput is one grant and one pop per cycle. Back-to-back pops with `event_ready` held high drain one entry per cycle.
- Pending bits wait indefinitely while the FIFO is full. They are granted on the first cycle after the count drops below FIFO_DEPTH.

## Configuration
- Macro: `BUTTON_EVENT_REPEAT_EN`.
- Defined:
  - The repeat target is the index of the latest press edge; the lowest index wins on simultaneous edges.
  - The counter reloads on every press edge.
  - While the target stays low, `pending[target]` is set REPEAT_DELAY cycles after the edge, then every REPEAT_PERIOD cycles.
  - Releasing the target stops repeating.
  - A repeat onto an already-pending bit is silently dropped, with no overflow.
- Undefined: no repeat logic or counter; exactly one event per press edge.

## Test plan
- Reset with buttons released → `event_valid`=0, `pending`=0, `overflow`=0. Holding `event_ready`=1 produces no events.
- Press bit 0 with `event_ready`=0 → `pending`=8'b0000_0001 after 1 edge, then `event_valid`=1 with `event_index`=0 after 2 edges. Valid holds until a one-cycle `event_ready` pops it.
- Press bits 0, 3 and 7 in the same cycle with `event_ready`=1 → events 0, 3, 7 on consecutive cycles; `overflow`=0.
- `event_ready`=0, press bits 0–5 together → FIFO holds 0, 1, 2, 3 and `pending`=8'b0011_0000. Raising `event_ready` then delivers 0, 1, 2, 3, 4, 5 in order with no overflow.
- FIFO full with `event_ready`=0; press, release and re-press bit 2 → `overflow`=1 on the second edge. A one-cycle `overflow_clear` → `overflow`=0.
- With `BUTTON_EVENT_REPEAT_EN`, hold bit 1 for 30 cycles with `event_ready`=1 → index-1 events at edge+2, +18, +22, +26, +30, then none after release. Without the macro → exactly one event.
